// File: rtl/mac_rx_crc_check.sv
// -----------------------------------------------------------------------------
// mac_rx_crc_check
//
// Receive-side MAC framer. Strips preamble/SFD, passes the frame from the
// destination address onward to a streaming sink and strips the 4-byte FCS.
// The frame is checked against the reflected CRC-32 residue. The last beat of
// each frame carries a bad-frame flag.
//
// Optional feature: define MAC_RX_LEN_CHECK_EN to also flag frames whose
// length (DA..FCS) is below 64 bytes or above MAX_FRAME_LEN.
//
// Ports
//   logic_clk       single rising-edge clock
//   logic_rstn      asynchronous active-low reset
//   phy_rxd_in      received byte
//   phy_rvalid_in   byte valid, high for the whole frame, low between frames
//   phy_rerr_in     PHY error flag, qualified by phy_rvalid_in
//   mac_tdata_out   payload byte (no backpressure)
//   mac_tvalid_out  beat valid
//   mac_tlast_out   last payload byte of the frame
//   mac_tuser_out   bad-frame flag, meaningful only with mac_tlast_out
// -----------------------------------------------------------------------------
module mac_rx_crc_check #(
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic       logic_clk,
    input  logic       logic_rstn,
    input  logic [7:0] phy_rxd_in,
    input  logic       phy_rvalid_in,
    input  logic       phy_rerr_in,
    output logic [7:0] mac_tdata_out,
    output logic       mac_tvalid_out,
    output logic       mac_tlast_out,
    output logic       mac_tuser_out
);

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE   = 32'h2144DF1C;
    localparam logic [7:0]  PRE_BYTE      = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  pre_cnt;
    logic [2:0]  fill;
    logic [7:0]  dline [4];
    logic [7:0]  pending;
    logic [31:0] crc;
    logic        err_seen;
    logic        rvalid_q;

    logic        pre_start;
    logic        pre_inc;
    logic        sfd_hit;
    logic        data_beat;
    logic        frame_end;
    logic        frame_bad;
    logic        crc_bad;

    logic [7:0]  tdata_nxt;
    logic        tvalid_nxt;
    logic        tlast_nxt;
    logic        tuser_nxt;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in,
                                               input logic [7:0]  d);
        logic [31:0] c;
        c = c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY_REFL;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign crc_bad = (~crc) != CRC_RESIDUE;

`ifdef MAC_RX_LEN_CHECK_EN
    logic [10:0] byte_cnt;
    logic        len_bad;

    always_ff @(posedge logic_clk or negedge logic_rstn) begin
        if (!logic_rstn) begin
            byte_cnt <= '0;
        end else if (sfd_hit) begin
            byte_cnt <= '0;
        end else if (data_beat && byte_cnt != '1) begin
            byte_cnt <= byte_cnt + 11'd1;
        end
    end

    assign len_bad   = (byte_cnt < 11'd64) || (32'(byte_cnt) > MAX_FRAME_LEN);
    assign frame_bad = crc_bad | err_seen | len_bad;
`else
    assign frame_bad = crc_bad | err_seen;
`endif

    // State register
    always_ff @(posedge logic_clk or negedge logic_rstn) begin
        if (!logic_rstn) state <= IDLE;
        else             state <= state_nxt;
    end

    // Next state, datapath strobes and next output beat
    always_comb begin
        state_nxt  = state;
        pre_start  = 1'b0;
        pre_inc    = 1'b0;
        sfd_hit    = 1'b0;
        data_beat  = 1'b0;
        frame_end  = 1'b0;
        tdata_nxt  = '0;
        tvalid_nxt = 1'b0;
        tlast_nxt  = 1'b0;
        tuser_nxt  = 1'b0;

        case (state)
            IDLE: begin
                // rvalid_q high here means the byte belongs to a frame that was
                // already running (only possible right after reset): drop it.
                if (phy_rvalid_in) begin
                    if (!rvalid_q && phy_rxd_in == PRE_BYTE) begin
                        state_nxt = PREAMBLE;
                        pre_start = 1'b1;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!phy_rvalid_in) begin
                    state_nxt = IDLE;
                end else if (phy_rerr_in) begin
                    state_nxt = DROP;
                end else if (phy_rxd_in == PRE_BYTE) begin
                    if (pre_cnt == 3'd7) state_nxt = DROP;
                    else                 pre_inc   = 1'b1;
                end else if (phy_rxd_in == SFD_BYTE) begin
                    state_nxt = DATA;
                    sfd_hit   = 1'b1;
                end else begin
                    state_nxt = DROP;
                end
            end
            DATA: begin
                if (phy_rvalid_in) begin
                    data_beat = 1'b1;
                    if (fill == 3'd5) begin
                        tdata_nxt  = pending;
                        tvalid_nxt = 1'b1;
                    end
                end else begin
                    frame_end = 1'b1;
                    state_nxt = IDLE;
                    // Pending holds the last payload byte; the delay line
                    // holds the FCS and is simply abandoned.
                    if (fill == 3'd5) begin
                        tdata_nxt  = pending;
                        tvalid_nxt = 1'b1;
                        tlast_nxt  = 1'b1;
                        tuser_nxt  = frame_bad;
                    end
                end
            end
            DROP: begin
                if (!phy_rvalid_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: preamble counter, FCS delay line, CRC, error flag, outputs
    always_ff @(posedge logic_clk or negedge logic_rstn) begin
        if (!logic_rstn) begin
            pre_cnt        <= '0;
            fill           <= '0;
            dline          <= '{default: '0};
            pending        <= '0;
            crc            <= '1;
            err_seen       <= 1'b0;
            rvalid_q       <= 1'b1;
            mac_tdata_out  <= '0;
            mac_tvalid_out <= 1'b0;
            mac_tlast_out  <= 1'b0;
            mac_tuser_out  <= 1'b0;
        end else begin
            rvalid_q       <= phy_rvalid_in;
            mac_tdata_out  <= tdata_nxt;
            mac_tvalid_out <= tvalid_nxt;
            mac_tlast_out  <= tlast_nxt;
            mac_tuser_out  <= tuser_nxt;

            if (pre_start)    pre_cnt <= 3'd1;
            else if (pre_inc) pre_cnt <= pre_cnt + 3'd1;

            if (sfd_hit) begin
                fill     <= '0;
                crc      <= '1;
                err_seen <= 1'b0;
            end else if (data_beat) begin
                crc      <= crc32_byte(crc, phy_rxd_in);
                dline[0] <= phy_rxd_in;
                dline[1] <= dline[0];
                dline[2] <= dline[1];
                dline[3] <= dline[2];
                pending  <= dline[3];
                if (fill != 3'd5) fill <= fill + 3'd1;
                if (phy_rerr_in)  err_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_rx_crc_check.sv
module tb_mac_rx_crc_check;

    localparam int unsigned MAX_FRAME_LEN = 1518;
`ifdef MAC_RX_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic       logic_clk;
    logic       logic_rstn;
    logic [7:0] phy_rxd_in;
    logic       phy_rvalid_in;
    logic       phy_rerr_in;
    logic [7:0] mac_tdata_out;
    logic       mac_tvalid_out;
    logic       mac_tlast_out;
    logic       mac_tuser_out;

    mac_rx_crc_check #(.MAX_FRAME_LEN(MAX_FRAME_LEN)) dut (
        .logic_clk      (logic_clk),
        .logic_rstn     (logic_rstn),
        .phy_rxd_in     (phy_rxd_in),
        .phy_rvalid_in  (phy_rvalid_in),
        .phy_rerr_in    (phy_rerr_in),
        .mac_tdata_out  (mac_tdata_out),
        .mac_tvalid_out (mac_tvalid_out),
        .mac_tlast_out  (mac_tlast_out),
        .mac_tuser_out  (mac_tuser_out)
    );

    initial logic_clk = 1'b0;
    always #5 logic_clk = ~logic_clk;

    typedef struct {
        int         npre;
        logic [7:0] sfd;
        int         plen;
        int         flip_idx;
        int         err_idx;
        int         gap;
        int         exp_beats;
        bit         exp_bad;   // CRC / rerr part; length rule added below
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   beat_no = 0;
    bit   mon_en  = 1'b0;

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge logic_clk) begin
        if (mon_en) begin
            n_total++;
            if (mac_tvalid_out) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat_unexpected: got data=%02h last=%0b user=%0b, required no beat",
                             mac_tdata_out, mac_tlast_out, mac_tuser_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (mac_tdata_out !== e.data || mac_tlast_out !== e.last ||
                        mac_tuser_out !== e.user) begin
                        n_bad++;
                        $display("FAIL beat_%0d: got data=%02h last=%0b user=%0b, required data=%02h last=%0b user=%0b",
                                 beat_no, mac_tdata_out, mac_tlast_out, mac_tuser_out,
                                 e.data, e.last, e.user);
                    end
                    beat_no++;
                end
            end else if (mac_tlast_out !== 1'b0 || mac_tuser_out !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_flags: got last=%0b user=%0b with tvalid=0, required 0 0",
                         mac_tlast_out, mac_tuser_out);
            end
        end
    end

    task automatic drive_byte(input logic [7:0] d, input logic e);
        @(posedge logic_clk);
        #1;
        phy_rxd_in    = d;
        phy_rvalid_in = 1'b1;
        phy_rerr_in   = e;
    endtask

    task automatic drive_gap(input int n);
        repeat (n) begin
            @(posedge logic_clk);
            #1;
            phy_rxd_in    = 8'h00;
            phy_rvalid_in = 1'b0;
            phy_rerr_in   = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_total++;
        if (mac_tdata_out !== 8'h00 || mac_tvalid_out !== 1'b0 ||
            mac_tlast_out !== 1'b0 || mac_tuser_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got data=%02h valid=%0b last=%0b user=%0b, required all 0",
                     name, mac_tdata_out, mac_tvalid_out, mac_tlast_out, mac_tuser_out);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0]  pl[$];
        logic [31:0] c;
        logic [31:0] fcs;
        bit          bad;
        exp_t        e;
        pl = {};
        c  = 32'hFFFFFFFF;
        for (int i = 0; i < v.plen; i++) begin
            pl.push_back(8'($urandom_range(0, 255)));
            c = crc_step(c, pl[i]);
        end
        fcs = ~c;
        if (v.flip_idx >= 0) pl[v.flip_idx] = pl[v.flip_idx] ^ 8'h01;
        bad = v.exp_bad || (LEN_CHK && ((v.plen + 4) < 64 || (v.plen + 4) > int'(MAX_FRAME_LEN)));
        for (int i = 0; i < v.exp_beats; i++) begin
            e.data = pl[i];
            e.last = (i == v.exp_beats - 1);
            e.user = e.last ? bad : 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < v.npre; i++) drive_byte(8'h55, 1'b0);
        drive_byte(v.sfd, 1'b0);
        for (int i = 0; i < v.plen; i++) drive_byte(pl[i], i == v.err_idx);
        for (int k = 0; k < 4; k++) drive_byte(fcs[8*k +: 8], 1'b0);
        drive_gap(v.gap);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge logic_clk);
            n++;
        end
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: got %0d beats still outstanding after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] c;
        logic [7:0]  pl[$];
        logic [31:0] fcs;
        exp_t        e;

        //               npre sfd    plen  flip err gap beats bad
        vecs[0]  = '{7, 8'hD5, 60,   -1,  -1, 1, 60,   1'b0};
        vecs[1]  = '{7, 8'hD5, 60,   10,  -1, 1, 60,   1'b1};
        vecs[2]  = '{7, 8'h5D, 60,   -1,  -1, 1, 0,    1'b0};
        vecs[3]  = '{7, 8'hD5, 60,   -1,  -1, 3, 60,   1'b0};
        vecs[4]  = '{7, 8'hD5, 60,   -1,  30, 1, 60,   1'b1};
        vecs[5]  = '{7, 8'hD5, 40,   -1,  -1, 2, 40,   1'b0};
        vecs[6]  = '{8, 8'hD5, 60,   -1,  -1, 1, 0,    1'b0};
        vecs[7]  = '{7, 8'hD5, 0,    -1,  -1, 1, 0,    1'b0};
        vecs[8]  = '{7, 8'hD5, 1,    -1,  -1, 1, 1,    1'b0};
        vecs[9]  = '{1, 8'hD5, 60,   -1,  -1, 1, 60,   1'b0};
        vecs[10] = '{7, 8'hD5, 1514, -1,  -1, 1, 1514, 1'b0};
        vecs[11] = '{7, 8'hD5, 1515, -1,  -1, 4, 1515, 1'b0};

        // Guard the bench's own CRC model with the standard check value
        c = 32'hFFFFFFFF;
        for (int k = 0; k < 9; k++) c = crc_step(c, 8'(8'h31 + k));
        if (~c !== 32'hCBF43926) begin
            $display("FAIL crc_model: got %08h, required cbf43926", ~c);
            $fatal(1, "bench CRC model broken");
        end

        logic_rstn    = 1'b0;
        phy_rxd_in    = 8'h00;
        phy_rvalid_in = 1'b0;
        phy_rerr_in   = 1'b0;
        #3;
        check_outputs_zero("reset_state");
        repeat (3) @(posedge logic_clk);
        #1;
        logic_rstn = 1'b1;
        mon_en     = 1'b1;
        drive_gap(2);

        for (int v = 0; v < 12; v++) run_vec(vecs[v]);
        wait_drain("drain_table", 40);
        drive_gap(3);

        // Reset while payload byte 20 is on the bus: beats 0..13 already out
        pl = {};
        c  = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            pl.push_back(8'($urandom_range(0, 255)));
            c = crc_step(c, pl[i]);
        end
        fcs = ~c;
        for (int i = 0; i < 14; i++) begin
            e.data = pl[i];
            e.last = 1'b0;
            e.user = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0);
        drive_byte(8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) drive_byte(pl[i], 1'b0);
        drive_byte(pl[20], 1'b0);
        logic_rstn = 1'b0;
        #1;
        check_outputs_zero("reset_midframe");
        for (int i = 21; i < 60; i++) begin
            drive_byte(pl[i], 1'b0);
            if (i == 22) logic_rstn = 1'b1;
        end
        for (int k = 0; k < 4; k++) drive_byte(fcs[8*k +: 8], 1'b0);
        drive_gap(1);
        wait_drain("drain_reset", 5);

        // Good frame after the interrupted one
        run_vec('{7, 8'hD5, 60, -1, -1, 2, 60, 1'b0});
        wait_drain("drain_after_reset", 40);
        drive_gap(5);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_rx_crc_check.md
MAC_RX_CRC_CHECK -- requirements
Module: mac_rx_crc_check

Interface
REQ-001 Parameter MAX_FRAME_LEN, default 1518, maximum legal frame length in bytes, destination address through FCS inclusive.
REQ-002 logic_clk  input  1  single clock; all logic rising-edge.
REQ-003 logic_rstn  input  1  reset, asynchronous, active-low.
REQ-004 phy_rxd_in  input  8  received byte, already in logic_clk domain.
REQ-005 phy_rvalid_in  input  1  byte valid; high continuously for one frame; low for at least 1 cycle between frames.
REQ-006 phy_rerr_in  input  1  PHY error flag, qualified by phy_rvalid_in.
REQ-007 mac_tdata_out  output  8  payload byte (destination address onward, FCS stripped).
REQ-008 mac_tvalid_out  output  1  beat valid; no backpressure; sink accepts every beat.
REQ-009 mac_tlast_out  output  1  last payload byte of frame.
REQ-010 mac_tuser_out  output  1  bad-frame flag, meaningful only with mac_tlast_out.

Function
REQ-011 FSM states IDLE, PREAMBLE, DATA, DROP; all transitions qualified by phy_rvalid_in unless stated.
REQ-012 IDLE: byte 0x55 -> PREAMBLE; any other valid byte -> DROP.
REQ-013 PREAMBLE: 0x55 stays, max 7 consecutive; 0xD5 (SFD) -> DATA; 8th 0x55 or any other byte -> DROP; rvalid low -> IDLE, no output.
REQ-014 DROP: no output; rvalid low -> IDLE.
REQ-015 DATA: every byte after SFD feeds CRC-32, poly 0x04C11DB7, reflected, init 0xFFFFFFFF, output XOR 0xFFFFFFFF (mac_lfsr, same configuration as the TX path).
REQ-016 FCS check: after last byte (FCS included), XORed CRC output SHALL equal residue 0x2144DF1C, else frame bad.
REQ-017 FCS stripping: 4-byte delay line plus 1-byte pending register; byte i is emitted (tvalid=1, tlast=0) the cycle after byte i+5 is sampled.
REQ-018 End of frame: first cycle rvalid low in DATA -> next cycle emit pending byte with tlast=1 and tuser=bad; delay-line contents (FCS) discarded; state -> IDLE.
REQ-019 Frame with fewer than 5 bytes after SFD: no beats emitted, no tlast.
REQ-020 Any phy_rerr_in=1 in PREAMBLE or DATA marks frame bad; in PREAMBLE, transition to DROP.
REQ-021 11-bit byte counter counts bytes after SFD, saturating at 2047; cleared on SFD.
REQ-022 tvalid low whenever no beat is emitted; tlast and tuser are 0 when tvalid is 0.
REQ-023 A new frame's preamble in the cycle a tlast beat is output SHALL be accepted normally.

Reset
REQ-024 Reset asserted: state IDLE, mac_tdata_out=0x00, mac_tvalid_out=0, mac_tlast_out=0, mac_tuser_out=0, CRC to 0xFFFFFFFF, counter and delay line cleared.
REQ-025 Reset mid-frame: frame discarded, no tlast emitted; after release, bytes are ignored until rvalid low (treated as DROP).

Configuration
REQ-026 Macro MAC_RX_LEN_CHECK_EN defined: frames with byte count < 64 or > MAX_FRAME_LEN are flagged bad (tuser=1), in addition to CRC and rerr.
REQ-027 MAC_RX_LEN_CHECK_EN undefined: no length check; bad = CRC mismatch or rerr only; counter logic removed.

Verification
REQ-028 7x0x55, 0xD5, 60-byte payload, correct FCS -> 60 beats matching payload, tlast on 60th, tuser=0.
REQ-029 Same frame with payload byte 10 XORed 0x01 -> 60 beats, tlast on 60th, tuser=1.
REQ-030 7x0x55 then 0x5D, then 64 bytes -> no output beats; next good frame received correctly.
REQ-031 Good 60-byte frame with phy_rerr_in=1 on byte 30 -> 60 beats, tuser=1.
REQ-032 MAC_RX_LEN_CHECK_EN defined, 40-byte payload with correct FCS -> 40 beats, tuser=1; undefined -> tuser=0.
REQ-033 logic_rstn low during byte 20 of DATA, then released -> outputs 0 immediately, no tlast, next good frame received with tuser=0.
